// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load/store at a time between the MAR/MDR
// datapath and a synchronous RAM. It range-checks the word address, pulses the
// RAM enable for a single cycle, waits out the read latency and reports
// completion with a one-cycle done pulse. All outputs are registered.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  output logic                  ram_read_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int CW = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic            store_op;
  logic [CW-1:0]   count;

  // Request sequencer: every output is updated here so none has a combinational path from an input.
  always_ff @(posedge clk) begin
    if (clear) begin
      state            <= IDLE;
      ready            <= 1'b1;
      done             <= 1'b0;
      err              <= 1'b0;
      rdata            <= '0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      ram_write_enable <= 1'b0;
      ram_read_enable  <= 1'b0;
      count            <= '0;
      store_op         <= 1'b0;
    end else begin
      done             <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_read_enable  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            store_op    <= we;
            ram_address <= addr[ADDR_WIDTH-1:0];
            ram_data_in <= wdata;
            ready       <= 1'b0;
            if (addr[31:ADDR_WIDTH] != '0) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state            <= ISSUE;
              ram_write_enable <= we;
              ram_read_enable  <= ~we;
            end
          end
        end
        ISSUE: begin
          if (store_op) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= WAIT;
            count <= CW'(READ_LATENCY);
          end
        end
        WAIT: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            rdata <= ram_data_out;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
